// File: rtl/spi_master_sequencer.sv
// spi_master_sequencer
// Mode-0 SPI master for the Wishbone SPI register block. A rising edge on the
// start level launches one full-duplex, MSB-first transfer to one of four
// devices. The received word and a sticky done flag are held for readback.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | CS high, SCLK low, waiting for a start rising edge
// ST_SETUP | CS low, SCLK low, CS-to-first-edge setup delay
// ST_SHIFT | SCLK toggling, CLK_DIV cycles per half-period, one bit per period
// ST_HOLD  | CS still low after the last SCLK fall, then release and report

module spi_master_sequencer #(
    parameter int DATA_W   = 32,
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [1:0]        sel_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o,
    output logic              busy_o,
    output logic              sclk_o,
    output logic              mosi_o,
    input  logic              miso_i,
    output logic [3:0]        cs_n_o
);

    // One down-counter times setup, both SCLK half-periods and hold, so it is
    // sized for the largest of the three delays.
    localparam int CNT_M1  = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX = (CNT_M1 > CS_HOLD) ? CNT_M1 : CS_HOLD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] HALF_LOAD  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(CS_HOLD - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD
    } state_t;

    state_t            state_q;
    logic              start_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [BIT_W-1:0]  bit_q;
    logic [DATA_W-1:0] tx_q;
    logic [DATA_W-1:0] rx_q;
    logic [DATA_W-1:0] data_q;
    logic              done_q;
    logic              busy_q;
    logic              sclk_q;
    logic              mosi_q;
    logic [3:0]        cs_n_q;
    logic              start_rise;

    assign start_rise = start_i & ~start_q;

    // Sequencer: start edge detect, timing, shifting and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            start_q <= 1'b0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            sclk_q  <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= 4'hF;
        end else begin
            start_q <= start_i;
            case (state_q)
                ST_IDLE: begin
                    // Edges arriving while busy were ignored elsewhere, so
                    // only an edge seen here can launch a transfer.
                    if (start_rise) begin
                        tx_q    <= data_i;
                        mosi_q  <= data_i[DATA_W-1];
                        cs_n_q  <= ~(4'b0001 << sel_i);
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= SETUP_LOAD;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        cnt_q   <= HALF_LOAD;
                        bit_q   <= '0;
                        state_q <= ST_SHIFT;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (!sclk_q) begin
                        sclk_q <= 1'b1;
                        rx_q   <= {rx_q[DATA_W-2:0], miso_i};
                        cnt_q  <= HALF_LOAD;
                    end else begin
                        sclk_q <= 1'b0;
                        if (bit_q == LAST_BIT) begin
                            // mosi keeps the last bit through the hold time
                            cnt_q   <= HOLD_LOAD;
                            state_q <= ST_HOLD;
                        end else begin
                            bit_q  <= bit_q + 1'b1;
                            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
                            mosi_q <= tx_q[DATA_W-2];
                            cnt_q  <= HALF_LOAD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        cs_n_q  <= 4'hF;
                        mosi_q  <= 1'b0;
                        data_q  <= rx_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign data_o = data_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign sclk_o = sclk_q;
    assign mosi_o = mosi_q;
    assign cs_n_o = cs_n_q;

endmodule
